// File: rtl/ysyx_22040750_axi_arbiter.sv
// Shares one AXI4 master between the icache (read-only) and dcache (read + write) controllers.
// Reads are arbitrated one burst at a time; dcache writes run on an independent AW->W->B sequencer.
module ysyx_22040750_axi_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
) (
    input  logic                I_clk,
    input  logic                I_rst,
    // icache read
    input  logic                I_i_arvalid,
    output logic                O_i_arready,
    input  logic [ADDR_W-1:0]   I_i_araddr,
    input  logic [7:0]          I_i_arlen,
    input  logic [2:0]          I_i_arsize,
    output logic [DATA_W-1:0]   O_i_rdata,
    output logic                O_i_rvalid,
    output logic                O_i_rlast,
    input  logic                I_i_rready,
    // dcache read
    input  logic                I_d_arvalid,
    output logic                O_d_arready,
    input  logic [ADDR_W-1:0]   I_d_araddr,
    input  logic [7:0]          I_d_arlen,
    input  logic [2:0]          I_d_arsize,
    output logic [DATA_W-1:0]   O_d_rdata,
    output logic                O_d_rvalid,
    output logic                O_d_rlast,
    input  logic                I_d_rready,
    // dcache write
    input  logic                I_d_awvalid,
    output logic                O_d_awready,
    input  logic [ADDR_W-1:0]   I_d_awaddr,
    input  logic [7:0]          I_d_awlen,
    input  logic [2:0]          I_d_awsize,
    input  logic                I_d_wvalid,
    output logic                O_d_wready,
    input  logic [DATA_W-1:0]   I_d_wdata,
    input  logic [DATA_W/8-1:0] I_d_wstrb,
    input  logic                I_d_wlast,
    output logic                O_d_bvalid,
    input  logic                I_d_bready,
    // AXI master
    output logic                O_axi_arvalid,
    output logic [ADDR_W-1:0]   O_axi_araddr,
    output logic [7:0]          O_axi_arlen,
    output logic [2:0]          O_axi_arsize,
    input  logic                I_axi_arready,
    input  logic [DATA_W-1:0]   I_axi_rdata,
    input  logic                I_axi_rvalid,
    input  logic                I_axi_rlast,
    output logic                O_axi_rready,
    output logic                O_axi_awvalid,
    output logic [ADDR_W-1:0]   O_axi_awaddr,
    output logic [7:0]          O_axi_awlen,
    output logic [2:0]          O_axi_awsize,
    input  logic                I_axi_awready,
    output logic                O_axi_wvalid,
    output logic [DATA_W-1:0]   O_axi_wdata,
    output logic [DATA_W/8-1:0] O_axi_wstrb,
    output logic                O_axi_wlast,
    input  logic                I_axi_wready,
    input  logic                I_axi_bvalid,
    output logic                O_axi_bready
);

    typedef enum logic [4:0] {
        RIdle  = 5'b00001,
        RArI   = 5'b00010,
        RArD   = 5'b00100,
        RDataI = 5'b01000,
        RDataD = 5'b10000
    } rd_state_e;

    typedef enum logic [1:0] {
        WIdle = 2'd0,
        WData = 2'd1,
        WResp = 2'd2
    } wr_state_e;

    localparam logic GrantI = 1'b0;
    localparam logic GrantD = 1'b1;

    rd_state_e         rd_state_q, rd_state_d;
    wr_state_e         wr_state_q, wr_state_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
    logic [7:0]        ar_len_q, ar_len_d;
    logic [2:0]        ar_size_q, ar_size_d;
    logic [7:0]        wr_beat_q, wr_beat_d;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            rd_state_q   <= RIdle;
            wr_state_q   <= WIdle;
            last_grant_q <= GrantI;
            ar_addr_q    <= '0;
            ar_len_q     <= '0;
            ar_size_q    <= '0;
            wr_beat_q    <= '0;
        end else begin
            rd_state_q   <= rd_state_d;
            wr_state_q   <= wr_state_d;
            last_grant_q <= last_grant_d;
            ar_addr_q    <= ar_addr_d;
            ar_len_q     <= ar_len_d;
            ar_size_q    <= ar_size_d;
            wr_beat_q    <= wr_beat_d;
        end
    end

    // Read arbiter: the AR payload is captured on the grant so the requester side stays untouched.
    always_comb begin
        rd_state_d    = rd_state_q;
        last_grant_d  = last_grant_q;
        ar_addr_d     = ar_addr_q;
        ar_len_d      = ar_len_q;
        ar_size_d     = ar_size_q;
        O_i_arready   = 1'b0;
        O_d_arready   = 1'b0;
        O_i_rdata     = '0;
        O_i_rvalid    = 1'b0;
        O_i_rlast     = 1'b0;
        O_d_rdata     = '0;
        O_d_rvalid    = 1'b0;
        O_d_rlast     = 1'b0;
        O_axi_arvalid = 1'b0;
        O_axi_araddr  = '0;
        O_axi_arlen   = '0;
        O_axi_arsize  = '0;
        O_axi_rready  = 1'b0;
        if (!I_rst) begin
            unique case (rd_state_q)
                RIdle: begin
                    // On a tie the side that did not own the previous burst wins.
                    if (I_d_arvalid && (!I_i_arvalid || last_grant_q == GrantI)) begin
                        rd_state_d = RArD;
                        ar_addr_d  = I_d_araddr;
                        ar_len_d   = I_d_arlen;
                        ar_size_d  = I_d_arsize;
                    end else if (I_i_arvalid) begin
                        rd_state_d = RArI;
                        ar_addr_d  = I_i_araddr;
                        ar_len_d   = I_i_arlen;
                        ar_size_d  = I_i_arsize;
                    end
                end
                RArI, RArD: begin
                    O_axi_arvalid = 1'b1;
                    O_axi_araddr  = ar_addr_q;
                    O_axi_arlen   = ar_len_q;
                    O_axi_arsize  = ar_size_q;
                    if (rd_state_q == RArI) O_i_arready = I_axi_arready;
                    else                    O_d_arready = I_axi_arready;
                    if (I_axi_arready) begin
                        rd_state_d = (rd_state_q == RArI) ? RDataI : RDataD;
                    end
                end
                RDataI: begin
                    O_i_rdata    = I_axi_rdata;
                    O_i_rvalid   = I_axi_rvalid;
                    O_i_rlast    = I_axi_rlast;
                    O_axi_rready = I_i_rready;
                    if (I_axi_rvalid && I_i_rready && I_axi_rlast) begin
                        rd_state_d   = RIdle;
                        last_grant_d = GrantI;
                    end
                end
                RDataD: begin
                    O_d_rdata    = I_axi_rdata;
                    O_d_rvalid   = I_axi_rvalid;
                    O_d_rlast    = I_axi_rlast;
                    O_axi_rready = I_d_rready;
                    if (I_axi_rvalid && I_d_rready && I_axi_rlast) begin
                        rd_state_d   = RIdle;
                        last_grant_d = GrantD;
                    end
                end
                default: rd_state_d = RIdle;
            endcase
        end
    end

    // Write sequencer: only one of AW, W, B is open at a time.
    always_comb begin
        wr_state_d    = wr_state_q;
        wr_beat_d     = wr_beat_q;
        O_d_awready   = 1'b0;
        O_d_wready    = 1'b0;
        O_d_bvalid    = 1'b0;
        O_axi_awvalid = 1'b0;
        O_axi_awaddr  = '0;
        O_axi_awlen   = '0;
        O_axi_awsize  = '0;
        O_axi_wvalid  = 1'b0;
        O_axi_wdata   = '0;
        O_axi_wstrb   = '0;
        O_axi_wlast   = 1'b0;
        O_axi_bready  = 1'b0;
        if (!I_rst) begin
            unique case (wr_state_q)
                WIdle: begin
                    O_axi_awvalid = I_d_awvalid;
                    O_axi_awaddr  = I_d_awaddr;
                    O_axi_awlen   = I_d_awlen;
                    O_axi_awsize  = I_d_awsize;
                    O_d_awready   = I_axi_awready;
                    if (I_d_awvalid && I_axi_awready) wr_state_d = WData;
                end
                WData: begin
                    O_axi_wvalid = I_d_wvalid;
                    O_axi_wdata  = I_d_wdata;
                    O_axi_wstrb  = I_d_wstrb;
                    O_axi_wlast  = I_d_wlast;
                    O_d_wready   = I_axi_wready;
                    if (I_d_wvalid && I_axi_wready) begin
                        wr_beat_d = wr_beat_q + 8'd1;
                        if (I_d_wlast) wr_state_d = WResp;
                    end
                end
                WResp: begin
                    O_d_bvalid   = I_axi_bvalid;
                    O_axi_bready = I_d_bready;
                    if (I_axi_bvalid && I_d_bready) begin
                        wr_state_d = WIdle;
                        wr_beat_d  = '0;
                    end
                end
                default: wr_state_d = WIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040750_axi_arbiter.sv
// Bench for ysyx_22040750_axi_arbiter: cache-side requesters, a simple AXI slave model
// and a scoreboard of expected R and W beats.
module tb_ysyx_22040750_axi_arbiter;

    logic        I_clk, I_rst;
    logic        I_i_arvalid, O_i_arready;
    logic [31:0] I_i_araddr;
    logic [7:0]  I_i_arlen;
    logic [2:0]  I_i_arsize;
    logic [63:0] O_i_rdata;
    logic        O_i_rvalid, O_i_rlast, I_i_rready;
    logic        I_d_arvalid, O_d_arready;
    logic [31:0] I_d_araddr;
    logic [7:0]  I_d_arlen;
    logic [2:0]  I_d_arsize;
    logic [63:0] O_d_rdata;
    logic        O_d_rvalid, O_d_rlast, I_d_rready;
    logic        I_d_awvalid, O_d_awready;
    logic [31:0] I_d_awaddr;
    logic [7:0]  I_d_awlen;
    logic [2:0]  I_d_awsize;
    logic        I_d_wvalid, O_d_wready;
    logic [63:0] I_d_wdata;
    logic [7:0]  I_d_wstrb;
    logic        I_d_wlast, O_d_bvalid, I_d_bready;
    logic        O_axi_arvalid;
    logic [31:0] O_axi_araddr;
    logic [7:0]  O_axi_arlen;
    logic [2:0]  O_axi_arsize;
    logic        I_axi_arready;
    logic [63:0] I_axi_rdata;
    logic        I_axi_rvalid, I_axi_rlast, O_axi_rready;
    logic        O_axi_awvalid;
    logic [31:0] O_axi_awaddr;
    logic [7:0]  O_axi_awlen;
    logic [2:0]  O_axi_awsize;
    logic        I_axi_awready;
    logic        O_axi_wvalid;
    logic [63:0] O_axi_wdata;
    logic [7:0]  O_axi_wstrb;
    logic        O_axi_wlast, I_axi_wready, I_axi_bvalid, O_axi_bready;

    int n_checks = 0;
    int n_fail   = 0;
    int ar_delay = 0;
    int b_seen   = 0;
    int w_beats  = 0;

    logic [64:0] i_exp[$];
    logic [64:0] d_exp[$];
    logic [72:0] w_exp[$];
    bit          grant_log[$];

    ysyx_22040750_axi_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
        .I_clk(I_clk), .I_rst(I_rst),
        .I_i_arvalid(I_i_arvalid), .O_i_arready(O_i_arready), .I_i_araddr(I_i_araddr),
        .I_i_arlen(I_i_arlen), .I_i_arsize(I_i_arsize), .O_i_rdata(O_i_rdata),
        .O_i_rvalid(O_i_rvalid), .O_i_rlast(O_i_rlast), .I_i_rready(I_i_rready),
        .I_d_arvalid(I_d_arvalid), .O_d_arready(O_d_arready), .I_d_araddr(I_d_araddr),
        .I_d_arlen(I_d_arlen), .I_d_arsize(I_d_arsize), .O_d_rdata(O_d_rdata),
        .O_d_rvalid(O_d_rvalid), .O_d_rlast(O_d_rlast), .I_d_rready(I_d_rready),
        .I_d_awvalid(I_d_awvalid), .O_d_awready(O_d_awready), .I_d_awaddr(I_d_awaddr),
        .I_d_awlen(I_d_awlen), .I_d_awsize(I_d_awsize), .I_d_wvalid(I_d_wvalid),
        .O_d_wready(O_d_wready), .I_d_wdata(I_d_wdata), .I_d_wstrb(I_d_wstrb),
        .I_d_wlast(I_d_wlast), .O_d_bvalid(O_d_bvalid), .I_d_bready(I_d_bready),
        .O_axi_arvalid(O_axi_arvalid), .O_axi_araddr(O_axi_araddr), .O_axi_arlen(O_axi_arlen),
        .O_axi_arsize(O_axi_arsize), .I_axi_arready(I_axi_arready), .I_axi_rdata(I_axi_rdata),
        .I_axi_rvalid(I_axi_rvalid), .I_axi_rlast(I_axi_rlast), .O_axi_rready(O_axi_rready),
        .O_axi_awvalid(O_axi_awvalid), .O_axi_awaddr(O_axi_awaddr), .O_axi_awlen(O_axi_awlen),
        .O_axi_awsize(O_axi_awsize), .I_axi_awready(I_axi_awready),
        .O_axi_wvalid(O_axi_wvalid), .O_axi_wdata(O_axi_wdata), .O_axi_wstrb(O_axi_wstrb),
        .O_axi_wlast(O_axi_wlast), .I_axi_wready(I_axi_wready), .I_axi_bvalid(I_axi_bvalid),
        .O_axi_bready(O_axi_bready)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [63:0] beat_data(input logic [31:0] addr, input int beat);
        return {addr, 32'(beat) ^ 32'hC0DE_0000};
    endfunction

    // AXI slave model: decides at the falling edge, drives just after the rising edge.
    initial begin : axi_slave
        logic        ar_hs, r_hs, w_last_hs, b_hs, rst_seen;
        logic [31:0] s_addr, hs_addr;
        logic [7:0]  s_len, hs_len;
        int          s_beat, ar_cnt;
        bit          s_busy;
        I_axi_arready = 0; I_axi_rdata = 0; I_axi_rvalid = 0; I_axi_rlast = 0;
        I_axi_awready = 0; I_axi_wready = 0; I_axi_bvalid = 0;
        s_addr = 0; s_len = 0; s_beat = 0; ar_cnt = 0; s_busy = 0;
        forever begin
            @(negedge I_clk);
            rst_seen  = I_rst;
            ar_hs     = O_axi_arvalid & I_axi_arready;
            r_hs      = I_axi_rvalid & O_axi_rready;
            w_last_hs = O_axi_wvalid & I_axi_wready & O_axi_wlast;
            b_hs      = I_axi_bvalid & O_axi_bready;
            hs_addr   = O_axi_araddr;
            hs_len    = O_axi_arlen;
            if (O_axi_arvalid && !I_axi_arready) ar_cnt++;
            @(posedge I_clk); #1;
            if (rst_seen) begin
                I_axi_arready = 0; I_axi_rvalid = 0; I_axi_rlast = 0; I_axi_rdata = 0;
                I_axi_awready = 0; I_axi_wready = 0; I_axi_bvalid = 0;
                s_busy = 0; ar_cnt = 0; s_beat = 0;
            end else begin
                if (ar_hs) begin
                    s_busy = 1; s_addr = hs_addr; s_len = hs_len; s_beat = 0; ar_cnt = 0;
                    I_axi_rvalid = 1;
                end else if (r_hs) begin
                    if (s_beat == int'(s_len)) begin
                        s_busy = 0;
                        I_axi_rvalid = 0;
                    end else begin
                        s_beat++;
                    end
                end
                I_axi_rdata   = beat_data(s_addr, s_beat);
                I_axi_rlast   = s_busy && (s_beat == int'(s_len));
                I_axi_arready = !s_busy && (ar_cnt >= ar_delay);
                I_axi_awready = 1;
                I_axi_wready  = ($urandom_range(0, 3) != 0);
                if (w_last_hs) I_axi_bvalid = 1;
                else if (b_hs) I_axi_bvalid = 0;
            end
        end
    end

    // Scoreboard: pops expected beats as the cache sides and the slave accept them.
    initial begin : monitor
        logic [64:0] e;
        logic [72:0] we;
        forever begin
            @(negedge I_clk);
            if (!I_rst) begin
                if (O_i_rvalid && i_exp.size() == 0) begin
                    n_fail++;
                    $display("FAIL i_rvalid_spurious: got rvalid=1 data=%h, required rvalid=0", O_i_rdata);
                end else if (O_i_rvalid && I_i_rready) begin
                    n_checks++;
                    e = i_exp.pop_front();
                    if ({O_i_rlast, O_i_rdata} !== e) begin
                        n_fail++;
                        $display("FAIL i_rbeat: got last=%b data=%h, required last=%b data=%h",
                                 O_i_rlast, O_i_rdata, e[64], e[63:0]);
                    end
                end
                if (O_d_rvalid && d_exp.size() == 0) begin
                    n_fail++;
                    $display("FAIL d_rvalid_spurious: got rvalid=1 data=%h, required rvalid=0", O_d_rdata);
                end else if (O_d_rvalid && I_d_rready) begin
                    n_checks++;
                    e = d_exp.pop_front();
                    if ({O_d_rlast, O_d_rdata} !== e) begin
                        n_fail++;
                        $display("FAIL d_rbeat: got last=%b data=%h, required last=%b data=%h",
                                 O_d_rlast, O_d_rdata, e[64], e[63:0]);
                    end
                end
                if (O_axi_wvalid && I_axi_wready) begin
                    n_checks++;
                    w_beats++;
                    if (w_exp.size() == 0) begin
                        n_fail++;
                        $display("FAIL w_beat_spurious: got data=%h, required no beat", O_axi_wdata);
                    end else begin
                        we = w_exp.pop_front();
                        if ({O_axi_wstrb, O_axi_wlast, O_axi_wdata} !== we) begin
                            n_fail++;
                            $display("FAIL w_beat: got strb=%h last=%b data=%h, required strb=%h last=%b data=%h",
                                     O_axi_wstrb, O_axi_wlast, O_axi_wdata, we[72:65], we[64], we[63:0]);
                        end
                    end
                end
                if (O_axi_arvalid && I_axi_arready) grant_log.push_back(O_d_arready);
                if (O_d_bvalid && I_d_bready) b_seen++;
            end
        end
    end

    task automatic do_reset();
        @(posedge I_clk); #1;
        I_rst = 1;
        I_i_arvalid = 0; I_i_araddr = 0; I_i_arlen = 0; I_i_arsize = 0; I_i_rready = 1;
        I_d_arvalid = 0; I_d_araddr = 0; I_d_arlen = 0; I_d_arsize = 0; I_d_rready = 1;
        I_d_awvalid = 0; I_d_awaddr = 0; I_d_awlen = 0; I_d_awsize = 0;
        I_d_wvalid = 0; I_d_wdata = 0; I_d_wstrb = 0; I_d_wlast = 0; I_d_bready = 0;
        repeat (2) @(posedge I_clk);
        #1 I_rst = 0;
        i_exp.delete(); d_exp.delete(); w_exp.delete(); grant_log.delete();
        b_seen = 0; w_beats = 0;
    endtask

    task automatic read_req(input bit is_d, input logic [31:0] addr, input logic [7:0] len);
        int n = 0;
        bit rdy = 0;
        @(posedge I_clk); #1;
        for (int b = 0; b <= int'(len); b++) begin
            if (is_d) d_exp.push_back({(b == int'(len)), beat_data(addr, b)});
            else      i_exp.push_back({(b == int'(len)), beat_data(addr, b)});
        end
        if (is_d) begin I_d_arvalid = 1; I_d_araddr = addr; I_d_arlen = len; I_d_arsize = 3'd3; end
        else      begin I_i_arvalid = 1; I_i_araddr = addr; I_i_arlen = len; I_i_arsize = 3'd3; end
        while (!rdy && n < 100) begin
            @(negedge I_clk);
            n++;
            rdy = is_d ? O_d_arready : O_i_arready;
        end
        n_checks++;
        if (!rdy) begin
            n_fail++;
            $display("FAIL ar_grant_timeout: side=%0d got arready=0 after %0d cycles, required 1", is_d, n);
        end
        @(posedge I_clk); #1;
        if (is_d) begin I_d_arvalid = 0; I_d_araddr = 0; I_d_arlen = 0; I_d_arsize = 0; end
        else      begin I_i_arvalid = 0; I_i_araddr = 0; I_i_arlen = 0; I_i_arsize = 0; end
    endtask

    task automatic write_req(input logic [31:0] addr, input logic [7:0] len);
        int n;
        @(posedge I_clk); #1;
        I_d_awvalid = 1; I_d_awaddr = addr; I_d_awlen = len; I_d_awsize = 3'd3;
        n = 0;
        do begin @(negedge I_clk); n++; end while (!O_d_awready && n < 100);
        n_checks++;
        if (!O_d_awready || O_axi_awaddr !== addr || O_axi_awlen !== len || !O_axi_awvalid) begin
            n_fail++;
            $display("FAIL aw_pass: got awready=%b awvalid=%b addr=%h len=%0d, required 1 1 %h %0d",
                     O_d_awready, O_axi_awvalid, O_axi_awaddr, O_axi_awlen, addr, len);
        end
        @(posedge I_clk); #1;
        I_d_awvalid = 0; I_d_awaddr = 0; I_d_awlen = 0; I_d_awsize = 0;
        for (int b = 0; b <= int'(len); b++) begin
            I_d_wvalid = 1;
            I_d_wdata  = {addr, 32'(b)} ^ 64'hFEED_0000_0000_1234;
            I_d_wstrb  = 8'hFF ^ 8'(b);
            I_d_wlast  = (b == int'(len));
            w_exp.push_back({I_d_wstrb, I_d_wlast, I_d_wdata});
            n = 0;
            do begin @(negedge I_clk); n++; end while (!O_d_wready && n < 100);
            n_checks++;
            if (!O_d_wready) begin
                n_fail++;
                $display("FAIL w_ready_timeout: beat %0d got wready=0, required 1", b);
            end
            @(posedge I_clk); #1;
        end
        I_d_wvalid = 0; I_d_wdata = 0; I_d_wstrb = 0; I_d_wlast = 0;
        I_d_bready = 1;
        n = 0;
        do begin @(negedge I_clk); n++; end while (!O_d_bvalid && n < 100);
        n_checks++;
        if (!O_d_bvalid) begin
            n_fail++;
            $display("FAIL b_timeout: got bvalid=0, required 1");
        end
        @(posedge I_clk); #1;
        I_d_bready = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((i_exp.size() != 0 || d_exp.size() != 0 || w_exp.size() != 0) && n < 300) begin
            @(negedge I_clk);
            n++;
        end
        n_checks++;
        if (i_exp.size() != 0 || d_exp.size() != 0 || w_exp.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got pending i=%0d d=%0d w=%0d, required 0 0 0",
                     i_exp.size(), d_exp.size(), w_exp.size());
        end
        repeat (2) @(posedge I_clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge I_clk); #1;
        I_rst = 1;
        I_d_awvalid = 1;
        @(negedge I_clk);
        n_checks++;
        if ({O_axi_arvalid, O_i_arready, O_d_arready, O_i_rvalid, O_d_rvalid, O_axi_rready,
             O_axi_awvalid, O_d_awready, O_axi_wvalid, O_d_wready, O_d_bvalid, O_axi_bready} !== 12'b0) begin
            n_fail++;
            $display("FAIL reset_handshakes: got nonzero valid/ready during reset, required all 0");
        end
        n_checks++;
        if ({O_axi_araddr, O_axi_awaddr, O_i_rdata, O_d_rdata, O_axi_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_payload: got araddr=%h awaddr=%h, required 0", O_axi_araddr, O_axi_awaddr);
        end
        do_reset();
        repeat (3) begin
            @(negedge I_clk);
            n_checks++;
            if (O_axi_arvalid !== 1'b0 || O_axi_awvalid !== 1'b0 || O_axi_rready !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_quiet: got arvalid=%b awvalid=%b rready=%b, required 0 0 0",
                         O_axi_arvalid, O_axi_awvalid, O_axi_rready);
            end
        end
    endtask

    task automatic test_icache_read();
        do_reset();
        @(posedge I_clk); #1;
        I_i_rready = 0;
        for (int b = 0; b < 4; b++) i_exp.push_back({(b == 3), beat_data(32'h8000_0000, b)});
        I_i_arvalid = 1; I_i_araddr = 32'h8000_0000; I_i_arlen = 8'd3; I_i_arsize = 3'd3;
        @(negedge I_clk);
        n_checks++;
        if (O_axi_arvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_latency_0: got arvalid=%b, required 0", O_axi_arvalid);
        end
        @(negedge I_clk);
        n_checks++;
        if (O_axi_arvalid !== 1'b1 || O_axi_araddr !== 32'h8000_0000 || O_axi_arlen !== 8'd3
            || O_i_arready !== 1'b1 || O_d_arready !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_latency_1: got arvalid=%b addr=%h len=%0d i_rdy=%b d_rdy=%b, required 1 80000000 3 1 0",
                     O_axi_arvalid, O_axi_araddr, O_axi_arlen, O_i_arready, O_d_arready);
        end
        @(posedge I_clk); #1;
        I_i_arvalid = 0; I_i_araddr = 0; I_i_arlen = 0;
        // rready held low: the first beat must wait at the slave, not be lost
        repeat (3) @(posedge I_clk);
        #1 I_i_rready = 1;
        drain();
    endtask

    task automatic test_round_robin();
        do_reset();
        fork
            read_req(1'b1, 32'h8000_2000, 8'd1);
            read_req(1'b0, 32'h8000_0100, 8'd1);
        join
        drain();
        fork
            read_req(1'b1, 32'h8000_2100, 8'd0);
            read_req(1'b0, 32'h8000_0200, 8'd2);
        join
        drain();
        n_checks++;
        if (grant_log.size() != 4) begin
            n_fail++;
            $display("FAIL rr_count: got %0d grants, required 4", grant_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (grant_log[k] !== ((k % 2) == 0)) begin
                    n_fail++;
                    $display("FAIL rr_order: grant %0d got dcache=%b, required %b", k, grant_log[k], (k % 2) == 0);
                end
            end
        end
    endtask

    task automatic test_mid_burst_request();
        int  cyc = 0, i_last_cyc = -1, d_ar_cyc = -1;
        bit  early = 0;
        do_reset();
        fork
            read_req(1'b0, 32'h8000_3000, 8'd7);
            begin
                repeat (4) @(posedge I_clk);
                read_req(1'b1, 32'h8000_4000, 8'd0);
            end
            begin
                while (d_ar_cyc < 0 && cyc < 80) begin
                    @(negedge I_clk);
                    cyc++;
                    if (O_i_rvalid && I_i_rready && O_i_rlast) i_last_cyc = cyc;
                    if (O_d_arready) begin
                        if (i_last_cyc < 0) early = 1;
                        d_ar_cyc = cyc;
                    end
                end
            end
        join
        drain();
        n_checks++;
        if (early || i_last_cyc < 0) begin
            n_fail++;
            $display("FAIL mid_burst_block: got d_arready before icache rlast (early=%0d), required none", early);
        end
        n_checks++;
        if (d_ar_cyc - i_last_cyc != 2) begin
            n_fail++;
            $display("FAIL mid_burst_gap: got d AR %0d cycles after rlast, required 2", d_ar_cyc - i_last_cyc);
        end
    endtask

    task automatic test_write_overlap();
        do_reset();
        fork
            read_req(1'b1, 32'h8000_2200, 8'd3);
            write_req(32'h8000_1000, 8'd3);
        join
        drain();
        n_checks++;
        if (w_beats != 4 || b_seen != 1) begin
            n_fail++;
            $display("FAIL write_burst: got %0d W beats and %0d B, required 4 and 1", w_beats, b_seen);
        end
    endtask

    task automatic test_reset_mid_burst();
        int n = 0;
        int seen = 0;
        do_reset();
        read_req(1'b1, 32'h8000_5000, 8'd3);
        while (seen < 1 && n < 50) begin
            @(negedge I_clk);
            n++;
            if (O_d_rvalid && I_d_rready) seen++;
        end
        @(posedge I_clk); #1;
        I_rst = 1;
        @(posedge I_clk); #1;
        I_rst = 0;
        d_exp.delete();
        @(negedge I_clk);
        n_checks++;
        if ({O_axi_arvalid, O_axi_araddr, O_axi_rready, O_d_rvalid, O_d_rdata, O_d_rlast, O_i_rvalid,
             O_i_arready, O_d_arready, O_axi_awvalid, O_axi_wvalid, O_d_wready, O_axi_bready,
             O_d_bvalid} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_burst: got d_rvalid=%b rready=%b arvalid=%b, required all outputs 0",
                     O_d_rvalid, O_axi_rready, O_axi_arvalid);
        end
        read_req(1'b0, 32'h8000_6000, 8'd1);
        drain();
    endtask

    task automatic test_arready_stall();
        int  n = 0, stalls = 0, pulses = 0;
        bit  bad = 0;
        do_reset();
        ar_delay = 5;
        repeat (2) @(posedge I_clk);
        fork
            read_req(1'b0, 32'h8000_7000, 8'd0);
            begin
                do begin @(negedge I_clk); n++; end while (!O_axi_arvalid && n < 20);
                while (O_axi_arvalid && n < 60) begin
                    if (O_axi_araddr !== 32'h8000_7000 || O_axi_arlen !== 8'd0) bad = 1;
                    if (O_i_arready && !I_axi_arready) bad = 1;
                    if (!I_axi_arready) stalls++;
                    if (O_i_arready) pulses++;
                    @(negedge I_clk);
                    n++;
                end
            end
        join
        ar_delay = 0;
        drain();
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL ar_stable: got payload change or early arready, required stable");
        end
        n_checks++;
        if (stalls != 5 || pulses != 1) begin
            n_fail++;
            $display("FAIL ar_stall: got stalls=%0d pulses=%0d, required 5 and 1", stalls, pulses);
        end
    endtask

    initial begin
        I_rst = 1;
        I_i_arvalid = 0; I_i_araddr = 0; I_i_arlen = 0; I_i_arsize = 0; I_i_rready = 1;
        I_d_arvalid = 0; I_d_araddr = 0; I_d_arlen = 0; I_d_arsize = 0; I_d_rready = 1;
        I_d_awvalid = 0; I_d_awaddr = 0; I_d_awlen = 0; I_d_awsize = 0;
        I_d_wvalid = 0; I_d_wdata = 0; I_d_wstrb = 0; I_d_wlast = 0; I_d_bready = 0;
        test_reset();
        test_icache_read();
        test_round_robin();
        test_mid_burst_request();
        test_write_overlap();
        test_reset_mid_burst();
        test_arready_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
